// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Time-multiplexed FIR filter for ECG denoising. One signed multiply-accumulate
// unit is shared across all NTAPS taps and stepped by a three-state FSM
// (IDLE -> MAC -> OUT). The sample history is a circular buffer. The
// coefficient bank is loaded at run time through the cfg_* port.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   in_valid    in   1      in_sample valid
//   in_ready    out  1      engine can accept a sample (IDLE only)
//   in_sample   in   DW     signed input sample
//   out_valid   out  1      out_result valid, held until out_ready
//   out_ready   in   1      downstream accepts out_result
//   out_result  out  OW     signed, shifted and saturated filter output
//   cfg_we      in   1      coefficient write strobe
//   cfg_addr    in   5      coefficient index
//   cfg_data    in   CW     signed coefficient value
//   cfg_err     out  1      one-cycle pulse: coefficient write rejected
//   busy        out  1      high in MAC and OUT
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
    parameter int NTAPS = 21,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int AW    = 40,
    parameter int SHIFT = 15,
    parameter int OW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_sample,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_result,
    input  logic                 cfg_we,
    input  logic [4:0]           cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 cfg_err,
    output logic                 busy
);

    localparam int            PW      = $clog2(NTAPS);
    localparam int            PRODW   = DW + CW;
    localparam logic [PW-1:0] LAST    = PW'(NTAPS - 1);
    localparam logic [5:0]    NTAPS_6 = 6'(NTAPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    state_t state_reg, state_next;

    logic [PW-1:0]          wp_reg;
    logic [PW-1:0]          rp_reg;
    logic [PW-1:0]          k_reg;
    logic signed [AW-1:0]   acc_reg;
    logic signed [OW-1:0]   out_result_reg;
    logic                   cfg_err_reg;

    logic signed [DW-1:0]   hist_rd [NTAPS];
    logic signed [CW-1:0]   coef_rd [NTAPS];

    logic                   accept;
    logic                   cfg_ok;
    logic                   cfg_bad;
    logic signed [PRODW-1:0] product;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   shifted;
    logic signed [OW-1:0]   sat_result;

    assign accept  = in_valid && (state_reg == ST_IDLE);
    assign cfg_ok  = cfg_we && (state_reg == ST_IDLE) && ({1'b0, cfg_addr} < NTAPS_6);
    assign cfg_bad = cfg_we && !cfg_ok;

    // History and coefficient storage. Both are cleared by reset, so they are
    // kept as individual registers rather than a RAM.
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
        logic signed [DW-1:0] hist_reg;
        logic signed [CW-1:0] coef_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hist_reg <= '0;
                coef_reg <= '0;
            end else begin
                if (accept && (wp_reg == PW'(gi)))
                    hist_reg <= in_sample;
                if (cfg_ok && (cfg_addr == 5'(gi)))
                    coef_reg <= cfg_data;
            end
        end

        assign hist_rd[gi] = hist_reg;
        assign coef_rd[gi] = coef_reg;
    end

    // Tap k multiplies the sample k steps back in time: rp starts at the slot
    // just written and walks backwards while k walks forwards.
    assign product  = hist_rd[rp_reg] * coef_rd[k_reg];
    assign prod_ext = {{(AW - PRODW){product[PRODW-1]}}, product};
    assign acc_sum  = acc_reg + prod_ext;
    assign shifted  = acc_sum >>> SHIFT;

    // Clamp the floor-shifted sum into the signed OW range.
    if (OW < AW) begin : g_sat
        localparam logic signed [AW-1:0] OUT_MAX = {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
        localparam logic signed [AW-1:0] OUT_MIN = {{(AW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

        always_comb begin
            sat_result = shifted[OW-1:0];
            if (shifted > OUT_MAX)
                sat_result = {1'b0, {(OW - 1){1'b1}}};
            else if (shifted < OUT_MIN)
                sat_result = {1'b1, {(OW - 1){1'b0}}};
        end
    end else begin : g_wide
        assign sat_result = OW'(shifted);
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (in_valid)         state_next = ST_MAC;
            ST_MAC:  if (k_reg == LAST)    state_next = ST_OUT;
            ST_OUT:  if (out_ready)        state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            wp_reg         <= '0;
            rp_reg         <= '0;
            k_reg          <= '0;
            acc_reg        <= '0;
            out_result_reg <= '0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= cfg_bad;
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        rp_reg  <= wp_reg;
                        k_reg   <= '0;
                        acc_reg <= '0;
                        wp_reg  <= (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
                    end
                end
                ST_MAC: begin
                    acc_reg <= acc_sum;
                    rp_reg  <= (rp_reg == '0) ? LAST : rp_reg - 1'b1;
                    if (k_reg == LAST) begin
                        // Final tap: the result includes this cycle's product.
                        k_reg          <= '0;
                        out_result_reg <= sat_result;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_OUT);
    assign busy       = (state_reg != ST_IDLE);
    assign out_result = out_result_reg;
    assign cfg_err    = cfg_err_reg;

endmodule
